// File: rtl/weight_pp_sched_if.sv
// weight_pp_sched_if: layer control, loader and MAC array handshakes of the weight ping-pong scheduler
interface weight_pp_sched_if #(
   parameter int TILE_W = 8
);
   logic              layer_start;
   logic [TILE_W-1:0] num_tiles;
   logic              load_done;
   logic              compute_done;
   logic              load_start;
   logic              load_bank;
   logic              comp_start;
   logic              comp_bank;
   logic [1:0]        bank_full;
   logic              busy;
   logic              layer_done;
   modport master (
      output layer_start, num_tiles, load_done, compute_done,
      input  load_start, load_bank, comp_start, comp_bank, bank_full, busy, layer_done
   );
   modport slave (
      input  layer_start, num_tiles, load_done, compute_done,
      output load_start, load_bank, comp_start, comp_bank, bank_full, busy, layer_done
   );
endinterface

// File: rtl/weight_pp_sched.sv
// weight_pp_sched: ping-pong weight bank scheduler overlapping the next tile's load with the current tile's compute
module weight_pp_sched #(
   parameter int TILE_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   weight_pp_sched_if.slave bus
);
   logic [TILE_W-1:0] num_q, num_d, load_cnt_q, load_cnt_d, comp_cnt_q, comp_cnt_d;
   logic [1:0]        full_q, full_d;
   logic              busy_q, busy_d, load_bank_q, load_bank_d, comp_bank_q, comp_bank_d;
   logic              loading_q, loading_d, computing_q, computing_d, ld_prev_q;
   logic              load_start_q, load_start_d, comp_start_q, comp_start_d, done_q, done_d;
   logic              load_fire, comp_fire;
   // a load completes only on a rising load_done while a load is in flight
   assign load_fire = loading_q && bus.load_done && !ld_prev_q;
   assign comp_fire = computing_q && bus.compute_done;
   always_comb begin
      num_d        = num_q;
      load_cnt_d   = load_cnt_q;
      comp_cnt_d   = comp_cnt_q;
      full_d       = full_q;
      busy_d       = busy_q;
      load_bank_d  = load_bank_q;
      comp_bank_d  = comp_bank_q;
      loading_d    = loading_q;
      computing_d  = computing_q;
      load_start_d = 1'b0;
      comp_start_d = 1'b0;
      done_d       = 1'b0;
      if (!busy_q) begin
         if (bus.layer_start) begin
            num_d       = bus.num_tiles;
            busy_d      = bus.num_tiles != '0;
            done_d      = bus.num_tiles == '0;
            load_cnt_d  = '0;
            comp_cnt_d  = '0;
            full_d      = '0;
            load_bank_d = 1'b0;
            comp_bank_d = 1'b0;
            loading_d   = 1'b0;
            computing_d = 1'b0;
         end
      end else begin
         if (load_fire) begin
            full_d[load_bank_q] = 1'b1;
            load_bank_d         = ~load_bank_q;
            load_cnt_d          = load_cnt_q + TILE_W'(1);
            loading_d           = 1'b0;
         end
         if (comp_fire) begin
            full_d[comp_bank_q] = 1'b0;
            comp_bank_d         = ~comp_bank_q;
            comp_cnt_d          = comp_cnt_q + TILE_W'(1);
            computing_d         = 1'b0;
            busy_d              = comp_cnt_d != num_q;
            done_d              = comp_cnt_d == num_q;
         end
         // starts are decided on registered state only, so each start lands one cycle after its enable
         if (!loading_q && load_cnt_q < num_q && !full_q[load_bank_q]) begin
            load_start_d = 1'b1;
            loading_d    = 1'b1;
         end
         if (!computing_q && comp_cnt_q < num_q && full_q[comp_bank_q]) begin
            comp_start_d = 1'b1;
            computing_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num_q        <= '0;
         load_cnt_q   <= '0;
         comp_cnt_q   <= '0;
         full_q       <= '0;
         busy_q       <= 1'b0;
         load_bank_q  <= 1'b0;
         comp_bank_q  <= 1'b0;
         loading_q    <= 1'b0;
         computing_q  <= 1'b0;
         ld_prev_q    <= 1'b0;
         load_start_q <= 1'b0;
         comp_start_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         num_q        <= num_d;
         load_cnt_q   <= load_cnt_d;
         comp_cnt_q   <= comp_cnt_d;
         full_q       <= full_d;
         busy_q       <= busy_d;
         load_bank_q  <= load_bank_d;
         comp_bank_q  <= comp_bank_d;
         loading_q    <= loading_d;
         computing_q  <= computing_d;
         ld_prev_q    <= bus.load_done;
         load_start_q <= load_start_d;
         comp_start_q <= comp_start_d;
         done_q       <= done_d;
      end
   end
   assign bus.load_start = load_start_q;
   assign bus.load_bank  = load_bank_q;
   assign bus.comp_start = comp_start_q;
   assign bus.comp_bank  = comp_bank_q;
   assign bus.bank_full  = full_q;
   assign bus.busy       = busy_q;
   assign bus.layer_done = done_q;
endmodule

// File: tb/tb_weight_pp_sched.sv
// tb_weight_pp_sched: directed and randomized layers checked every cycle against a per-tile timing model
module tb_weight_pp_sched;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   weight_pp_sched_if #(.TILE_W(8)) bus ();
   weight_pp_sched #(.TILE_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   int   cyc = 0;
   int   mode = 0;
   int   phase = 0;
   int   t0 = 0;
   int   n_to = 0;
   int   seen_to = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic man_ld = 1'b0, auto_ld = 1'b0, man_cd = 1'b0, auto_cd = 1'b0;
   assign bus.load_done    = (mode == 0) ? man_ld : auto_ld;
   assign bus.compute_done = (mode == 0) ? man_cd : auto_cd;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic at_r(input int k);
      while (cyc - t0 < k) tick();
   endtask
   task automatic start(input int k);
      bus.layer_start = 1'b1;
      bus.num_tiles   = 8'(k);
   endtask
   task automatic wait_done(input int lim);
      int k;
      k = 0;
      while (!bus.layer_done && k < lim) begin
         tick();
         k++;
      end
      if (!bus.layer_done) n_to++;
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask
   // model: tile i lives in bank i%2; a start follows its last enabling event by two cycles
   bit   has = 0;
   int   A = 0, n = 0, nl = 0, nc = 0;
   int   ldone[256];
   int   cdone[256];
   logic prev = 1'b0;
   int   ls5 = 0, cs5 = 0, ld5 = 0, first_cd5 = -1, third_ls5 = -1;
   bit   p6_done = 0;
   always @(negedge clk) begin
      int ls_t, cs_t, r;
      logic [1:0] bf;
      bit be, ld_go, cd_go, done_e;
      if (!rst_n) begin
         chk("rst_load_start", bus.load_start, 0);
         chk("rst_comp_start", bus.comp_start, 0);
         chk("rst_load_bank", bus.load_bank, 0);
         chk("rst_comp_bank", bus.comp_bank, 0);
         chk("rst_bank_full", bus.bank_full, 0);
         chk("rst_busy", bus.busy, 0);
         chk("rst_layer_done", bus.layer_done, 0);
         has = 0; n = 0; nl = 0; nc = 0; prev = 1'b0;
      end else begin
         be = has && cyc >= A + 1 && nc < n;
         ls_t = -1;
         if (has && nl < n && (nl < 2 || nc > nl - 2)) begin
            ls_t = A + 2;
            if (nl > 0 && ldone[nl-1] + 2 > ls_t) ls_t = ldone[nl-1] + 2;
            if (nl >= 2 && cdone[nl-2] + 2 > ls_t) ls_t = cdone[nl-2] + 2;
         end
         cs_t = -1;
         if (nc < nl) begin
            cs_t = ldone[nc] + 2;
            if (nc > 0 && cdone[nc-1] + 2 > cs_t) cs_t = cdone[nc-1] + 2;
         end
         bf = 2'b00;
         for (int i = nc; i < nl; i++) bf[i%2] = 1'b1;
         done_e = has && ((n == 0) ? (cyc == A + 1) : (nc == n && cdone[n-1] == cyc - 1));
         chk("busy", bus.busy, be);
         chk("load_start", bus.load_start, ls_t == cyc);
         chk("comp_start", bus.comp_start, cs_t == cyc);
         chk("load_bank", bus.load_bank, nl % 2);
         chk("comp_bank", bus.comp_bank, nc % 2);
         chk("bank_full", bus.bank_full, bf);
         chk("layer_done", bus.layer_done, done_e);
         r = cyc - t0;
         if (phase == 1 && r == 1) chk("p1_busy", bus.busy, 1);
         if (phase == 1 && r == 2) begin
            chk("p1_load_start", bus.load_start, 1);
            chk("p1_load_bank", bus.load_bank, 0);
         end
         if (phase == 2) begin
            if (r == 2)  chk("single_load_start", bus.load_start, 1);
            if (r == 11) chk("single_full", bus.bank_full, 1);
            if (r == 11) chk("single_load_bank", bus.load_bank, 1);
            if (r == 12) chk("single_comp_start", bus.comp_start, 1);
            if (r == 12) chk("single_comp_bank", bus.comp_bank, 0);
            if (r == 21) chk("single_layer_done", bus.layer_done, 1);
            if (r == 21) chk("single_busy_off", bus.busy, 0);
            if (r == 22) chk("b2b_busy", bus.busy, 1);
            if (r == 22) chk("b2b_full_clear", bus.bank_full, 0);
            if (r == 23) chk("b2b_load_start", bus.load_start, 1);
            if (r == 23) chk("b2b_load_bank", bus.load_bank, 0);
            if (r == 32) chk("simul_full", bus.bank_full, 2);
            if (r == 33) chk("simul_comp_bank", bus.comp_bank, 1);
            if (r == 33) chk("simul_comp_start", bus.comp_start, 1);
            if (r == 37) chk("b2b_layer_done", bus.layer_done, 1);
         end
         if (phase == 3) begin
            if (r == 3)  chk("spur_load_start", bus.load_start, 1);
            if (r == 5)  chk("spur_busy", bus.busy, 1);
            if (r == 5)  chk("spur_full", bus.bank_full, 0);
            if (r == 9)  chk("spur_full_set", bus.bank_full, 1);
            if (r == 16) chk("spur_layer_done", bus.layer_done, 1);
         end
         if (phase == 4 && r == 1) chk("zero_layer_done", bus.layer_done, 1);
         if (phase == 4 && r == 1) chk("zero_busy", bus.busy, 0);
         if (phase == 4 && r == 2) chk("zero_done_pulse", bus.layer_done, 0);
         if (phase == 5) begin
            if (bus.load_start) ls5++;
            if (bus.load_start && ls5 == 3) third_ls5 = cyc;
            if (bus.comp_start) cs5++;
            if (bus.layer_done) ld5++;
            if (bus.compute_done && first_cd5 < 0) first_cd5 = cyc;
         end
         if (phase == 6 && !p6_done) begin
            p6_done = 1;
            chk("pp_load_starts", ls5, 4);
            chk("pp_comp_starts", cs5, 4);
            chk("pp_layer_dones", ld5, 1);
            chk("pp_first_cd", first_cd5 - t0, 29);
            chk("pp_third_load_gap", third_ls5 - first_cd5, 2);
         end
         ld_go = has && nl < n && ls_t >= 0 && ls_t <= cyc;
         cd_go = cs_t >= 0 && cs_t <= cyc;
         if (ld_go && bus.load_done && !prev) begin
            ldone[nl] = cyc;
            nl++;
         end
         if (cd_go && bus.compute_done) begin
            cdone[nc] = cyc;
            nc++;
         end
         prev = bus.load_done;
         if (!be && bus.layer_start) begin
            has = 1; A = cyc; n = int'(bus.num_tiles); nl = 0; nc = 0;
         end
      end
      if (n_to != seen_to) begin
         chk("layer_done_timeout", n_to, seen_to);
         seen_to = n_to;
      end
   end
   initial begin
      int d;
      tick();
      forever begin
         if (mode != 0 && bus.load_start) begin
            d = (mode == 1) ? 5 : int'($urandom_range(1, 7));
            repeat (d) tick();
            auto_ld = 1'b1;
            d = (mode == 1) ? 1 : int'($urandom_range(1, 2));
            repeat (d) tick();
            auto_ld = 1'b0;
         end else tick();
      end
   end
   initial begin
      int d;
      tick();
      forever begin
         if (mode != 0 && bus.comp_start) begin
            d = (mode == 1) ? 20 : int'($urandom_range(1, 25));
            repeat (d) tick();
            auto_cd = 1'b1;
            tick();
            auto_cd = 1'b0;
         end else tick();
      end
   end
   initial begin
      #1000000;
      $display("FAIL global_timeout at cycle %0d: got no finish expected finish", cyc);
      $fatal(1);
   end
   initial begin
      bus.layer_start = 1'b0;
      bus.num_tiles   = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      start(3);
      tick();
      bus.layer_start = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick(); t0 = cyc; phase = 1;
      start(3);
      at_r(1); bus.layer_start = 1'b0;
      at_r(4); rst_n = 1'b0;
      at_r(5); rst_n = 1'b1;
      tick(); t0 = cyc; phase = 2;
      start(1);
      at_r(1);  bus.layer_start = 1'b0;
      at_r(10); man_ld = 1'b1;
      at_r(11); man_ld = 1'b0;
      at_r(20); man_cd = 1'b1;
      at_r(21); man_cd = 1'b0; start(2);
      at_r(22); bus.layer_start = 1'b0;
      at_r(25); man_ld = 1'b1;
      at_r(26); man_ld = 1'b0;
      at_r(31); man_ld = 1'b1; man_cd = 1'b1;
      at_r(32); man_ld = 1'b0; man_cd = 1'b0;
      at_r(36); man_cd = 1'b1;
      at_r(37); man_cd = 1'b0;
      at_r(40);
      tick(); t0 = cyc; phase = 3;
      man_ld = 1'b1;
      at_r(1);  start(1);
      at_r(2);  bus.layer_start = 1'b0;
      at_r(4);  man_cd = 1'b1; start(7);
      at_r(5);  man_cd = 1'b0; bus.layer_start = 1'b0;
      at_r(6);  man_ld = 1'b0;
      at_r(8);  man_ld = 1'b1;
      at_r(12); man_ld = 1'b0;
      at_r(15); man_cd = 1'b1;
      at_r(16); man_cd = 1'b0;
      at_r(18);
      tick(); t0 = cyc; phase = 4;
      start(0);
      at_r(1); bus.layer_start = 1'b0;
      at_r(3);
      mode = 1;
      tick(); t0 = cyc; phase = 5;
      start(4);
      tick();
      bus.layer_start = 1'b0;
      wait_done(400);
      repeat (3) tick();
      phase = 6;
      tick();
      mode = 2;
      phase = 7;
      for (int l = 0; l < 10; l++) begin
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
         start(int'($urandom_range(0, 12)));
         tick();
         bus.layer_start = 1'b0;
         wait_done(3000);
      end
      repeat (3) tick();
      mode = 0;
      phase = 8;
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/weight_pp_sched.md
# weight_pp_sched

Tile-level scheduler for the ping-pong weight BRAM banks (bank 0 = bce0/bce1 pair, bank 1 = bce2/bce3 pair).
- Issues load requests to the weight loader and compute requests to the MAC array, so the next tile's weights are fetched into the idle bank while the current tile computes from the other bank.
- Tracks per-bank full/empty state and tile counts for one layer.
- Signals layer completion.

## Interface
Parameters:
- TILE_W, 8, width of tile count and internal tile counters

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- layer_start  in  1  single-cycle request to run one layer; accepted only when busy=0
- num_tiles  in  TILE_W  tiles in layer; sampled on accepted layer_start
- load_done  in  1  loader completion level; completion event = rising edge while loading
- compute_done  in  1  single-cycle pulse from MAC array; accepted only while computing
- load_start  out  1  single-cycle pulse to weight loader
- load_bank  out  1  bank the current/next load targets
- comp_start  out  1  single-cycle pulse to MAC array
- comp_bank  out  1  bank the current/next compute reads
- bank_full  out  2  per-bank "holds unconsumed weights" flags
- busy  out  1  layer in progress
- layer_done  out  1  single-cycle pulse at layer end

## Operation
- Reset values: all outputs 0; internal flags loading/computing 0; counters 0; load_done edge-detect register 0.
- Accepted layer_start latches num_tiles and sets busy. It also clears load_cnt, comp_cnt, bank_full, load_bank, comp_bank, loading and computing.
- layer_start while busy=1: ignored, no state change.
- num_tiles=0: busy stays 0, layer_done pulses, no load_start/comp_start.
- Load engine issues load_start when all of these hold: busy, !loading, load_cnt<num_tiles, bank_full[load_bank]=0. It then sets loading=1.
- Load completion, when loading and load_done rises (high now, low last cycle):
  - bank_full[load_bank]<=1, load_bank toggles, load_cnt+1, loading<=0.
  - load_done rising while !loading: ignored.
- Compute engine issues comp_start when all of these hold: busy, !computing, comp_cnt<num_tiles, bank_full[comp_bank]=1. It then sets computing=1.
- Compute completion, when computing and compute_done=1:
  - bank_full[comp_bank]<=0, comp_bank toggles, comp_cnt+1, computing<=0.
  - compute_done while !computing: ignored.
- Load and compute on the same bank are mutually exclusive by construction (full vs empty precondition). A same-cycle load completion and compute completion therefore touch different banks, and both apply.
- Layer end: on the compute completion that makes comp_cnt==num_tiles, busy<=0 and layer_done pulses.
- Counters are TILE_W wide; num_tiles max 2^TILE_W-1; no wrap within a layer.
- Async reset mid-layer aborts immediately to reset values; no layer_done.

## Timing
- All outputs registered. A start pulse rises one cycle after its enabling condition is visible in registered state.
- layer_start in cycle 0 → busy=1 in cycle 1 → load_start (bank 0) in cycle 2.
- load_done rises in cycle n → bank_full[b]=1 and load_bank toggled in cycle n+1.
  - comp_start on b in cycle n+2 if compute idle.
  - load_start on the other bank in cycle n+2 if it is empty and tiles remain.
- compute_done in cycle m → bank_full[b]=0 in cycle m+1 → a blocked load_start into b in cycle m+2.
- Last compute_done in cycle m → layer_done=1 and busy=0 in cycle m+1. The earliest new layer_start is accepted in cycle m+1.
- load_start/comp_start are never high two consecutive cycles.

## Test plan
- Reset: assert rst_n=0 mid-layer → all outputs 0 immediately. Release, then layer_start with num_tiles=3 → load_start in cycle 2 with load_bank=0.
- Single tile (num_tiles=1):
  - Stimulus: load_done rises cycle 10, compute_done cycle 20.
  - Response: comp_start cycle 12 comp_bank=0, no second load_start, layer_done cycle 21.
- Ping-pong overlap (num_tiles=4, loads 5 cycles, computes 20 cycles):
  - Loads alternate bank 0,1,0,1.
  - The third load_start waits until 2 cycles after the first compute_done.
  - Exactly 4 load_start and 4 comp_start; layer_done once.
- Simultaneous events: load_done rising on bank 1 in the same cycle as compute_done on bank 0 → next cycle bank_full=2'b10, both counters incremented.
- Spurious inputs:
  - load_done held high from idle while not loading, compute_done while not computing, layer_start while busy → no state change.
  - num_tiles=0 → layer_done in cycle 1, busy stays 0.
- Back-to-back layers: layer_start in the layer_done cycle → accepted. Banks restart at 0 and bank_full is cleared.
